gpr_xfer_ctrl: RTL and testbench
================================

GPR_XFER_CTRL -- requirements
Module: gpr_xfer_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the general-purpose registers and immediate.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  2  operation: 00 LDI, 01 MOV, 10 SWAP, 11 CLR.
REQ-007 cmd_rd  input  2  destination register index.
REQ-008 cmd_rs  input  2  source register index (MOV, SWAP only).
REQ-009 cmd_imm  input  WIDTH  immediate for LDI.
REQ-010 rf_rdata  input  WIDTH  register-file read-port data, combinational from rf_sel_read.
REQ-011 rf_sel_read  output  2  register-file read select.
REQ-012 rf_sel_write  output  2  register-file write select.
REQ-013 rf_wdata  output  WIDTH  register-file write data.
REQ-014 rf_load  output  4  one-hot write enables, bit i drives load of register Ri.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on the final write cycle of a command.
REQ-017 err  output  1  one-cycle pulse for a rejected opcode.

Function
REQ-018 Handshake: command accepted on rising edge where cmd_valid and cmd_ready are both 1; cmd_op, cmd_rd, cmd_rs, cmd_imm latched at acceptance; later input changes are ignored until the next acceptance.
REQ-019 cmd_ready SHALL be 1 only in IDLE with rst low; at most one command in flight.
REQ-020 States: IDLE, RD_S, RD_D, WR_D, WR_S.
REQ-021 LDI: IDLE -> WR_D; in WR_D, rf_sel_write=rd, rf_wdata=imm, rf_load=1<<rd, done=1; -> IDLE. Write occurs 1 cycle after acceptance.
REQ-022 CLR: identical to LDI with rf_wdata=0.
REQ-023 MOV: IDLE -> RD_S (rf_sel_read=rs, tmpA<=rf_rdata) -> WR_D (write tmpA to rd, done=1) -> IDLE; 2-cycle latency.
REQ-024 SWAP: IDLE -> RD_S (tmpA<=R[rs]) -> RD_D (rf_sel_read=rd, tmpB<=rf_rdata) -> WR_D (write tmpA to rd) -> WR_S (write tmpB to rs, done=1) -> IDLE; 4-cycle latency.
REQ-025 rs==rd for MOV/SWAP SHALL complete with normal timing and leave the register value unchanged.
REQ-026 rf_load SHALL be zero in IDLE, RD_S and RD_D; never more than one bit set.
REQ-027 rf_sel_write and rf_wdata SHALL be 0 whenever rf_load is 0; rf_sel_read SHALL be 0 outside RD_S/RD_D.
REQ-028 Back-to-back: cmd_ready rises the cycle after done; a new command is accepted no earlier than that cycle.

Reset
REQ-029 While rst is high: state=IDLE, tmpA=tmpB=0, cmd_ready=0, busy=0, done=0, err=0, rf_load=0, rf_sel_read=0, rf_sel_write=0, rf_wdata=0.
REQ-030 Reset asserted mid-command SHALL abort it; no rf_load is asserted after the reset edge and no done pulse is issued for the aborted command.
REQ-031 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro SWAP_OP_EN: when defined, SWAP is implemented per REQ-024.
REQ-033 When SWAP_OP_EN is undefined, op 10 is accepted, no rf_load is asserted, err pulses 1 cycle after acceptance, done stays 0, and the controller returns to IDLE; states RD_D and WR_S are not built.

Verification
REQ-034 LDI rd=2 imm=0xA5 -> one cycle later rf_load=0100, rf_sel_write=2, rf_wdata=0xA5, done=1.
REQ-035 R1=0x3C, MOV rs=1 rd=3 -> RD_S: rf_sel_read=1; next cycle rf_load=1000, rf_wdata=0x3C, done=1.
REQ-036 R0=0x11, R3=0x22, SWAP rs=0 rd=3 (SWAP_OP_EN defined) -> writes 0x11 to R3, then 0x22 to R0; done on the 4th cycle after acceptance; without the macro -> err pulse, no rf_load.
REQ-037 cmd_valid held high with two queued commands (CLR rd=1, LDI rd=1 imm=0x7F) -> second accepted only after the first done; R1 ends at 0x7F.
REQ-038 rst asserted in RD_D of a SWAP -> no rf_load thereafter, done=0, cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/gpr_xfer_ctrl.sv
// gpr_xfer_ctrl -- sequencer for transfers between four general-purpose
// registers held in an external register file.
//
// Operations (cmd_op): 00 LDI rd<=imm, 01 MOV rd<=rs, 10 SWAP rd<->rs,
// 11 CLR rd<=0. One command is in flight at a time. Fields are captured
// when the command is accepted, so the requester may change them afterwards.
//
// Build option: define SWAP_OP_EN to build the SWAP sequence
// (RD_S -> RD_D -> WR_D -> WR_S). Without it, SWAP is accepted, answered
// with a one-cycle err pulse, and never writes the register file.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_op, cmd_rd, cmd_rs    opcode, destination and source indices
//   cmd_imm                   immediate for LDI
//   rf_rdata                  register-file read data (combinational from rf_sel_read)
//   rf_sel_read               register-file read select
//   rf_sel_write, rf_wdata    register-file write select and data
//   rf_load                   one-hot write enables, bit i loads Ri
//   busy                      controller is executing a command
//   done                      pulse on the final write cycle of a command
//   err                       pulse for a rejected opcode
module gpr_xfer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic [1:0]       rf_sel_read,
  output logic [1:0]       rf_sel_write,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [3:0]       rf_load,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_S = 3'd1,
    WR_D = 3'd2
`ifdef SWAP_OP_EN
    ,
    RD_D = 3'd3,
    WR_S = 3'd4
`endif
  } state_t;

  state_t     state_reg;
  logic [1:0] rd_reg;
`ifdef SWAP_OP_EN
  logic [1:0]       rs_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] tmp_a_reg;
  logic [WIDTH-1:0] tmp_b_reg;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Gated with rst so the handshake is closed for the whole reset period
  // and opens in the very first cycle after rst falls.
  assign cmd_ready = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_reg       <= '0;
      rf_sel_read  <= '0;
      rf_sel_write <= '0;
      rf_wdata     <= '0;
      rf_load      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
`ifdef SWAP_OP_EN
      rs_reg       <= '0;
      op_reg       <= '0;
      tmp_a_reg    <= '0;
      tmp_b_reg    <= '0;
`endif
    end else begin
      // Every output is a one-state pulse; defaults return them to zero so
      // that select/data lines are quiet whenever no write is enabled.
      rf_sel_read  <= '0;
      rf_sel_write <= '0;
      rf_wdata     <= '0;
      rf_load      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;

      case (state_reg)
        IDLE: begin
          // In IDLE with rst low cmd_ready is 1, so cmd_valid alone accepts.
          if (cmd_valid) begin
            rd_reg <= cmd_rd;
`ifdef SWAP_OP_EN
            rs_reg <= cmd_rs;
            op_reg <= cmd_op;
`endif
            case (cmd_op)
              OP_LDI: begin
                state_reg    <= WR_D;
                rf_load      <= onehot(cmd_rd);
                rf_sel_write <= cmd_rd;
                rf_wdata     <= cmd_imm;
                done         <= 1'b1;
              end
              OP_CLR: begin
                state_reg    <= WR_D;
                rf_load      <= onehot(cmd_rd);
                rf_sel_write <= cmd_rd;
                done         <= 1'b1;
              end
              OP_MOV: begin
                state_reg   <= RD_S;
                rf_sel_read <= cmd_rs;
              end
              OP_SWAP: begin
`ifdef SWAP_OP_EN
                state_reg   <= RD_S;
                rf_sel_read <= cmd_rs;
`else
                // Accepted but unsupported: stay idle and flag it.
                err <= 1'b1;
`endif
              end
            endcase
          end
        end

        RD_S: begin
`ifdef SWAP_OP_EN
          tmp_a_reg <= rf_rdata;
          if (op_reg == OP_SWAP) begin
            state_reg   <= RD_D;
            rf_sel_read <= rd_reg;
          end else begin
            // MOV: the read data goes straight to the write port.
            state_reg    <= WR_D;
            rf_load      <= onehot(rd_reg);
            rf_sel_write <= rd_reg;
            rf_wdata     <= rf_rdata;
            done         <= 1'b1;
          end
`else
          state_reg    <= WR_D;
          rf_load      <= onehot(rd_reg);
          rf_sel_write <= rd_reg;
          rf_wdata     <= rf_rdata;
          done         <= 1'b1;
`endif
        end

`ifdef SWAP_OP_EN
        RD_D: begin
          // Both operands are captured before either write, so rs == rd
          // rewrites the same value twice and leaves the register intact.
          tmp_b_reg    <= rf_rdata;
          state_reg    <= WR_D;
          rf_load      <= onehot(rd_reg);
          rf_sel_write <= rd_reg;
          rf_wdata     <= tmp_a_reg;
        end
`endif

        WR_D: begin
`ifdef SWAP_OP_EN
          if (op_reg == OP_SWAP) begin
            state_reg    <= WR_S;
            rf_load      <= onehot(rs_reg);
            rf_sel_write <= rs_reg;
            rf_wdata     <= tmp_b_reg;
            done         <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
`else
          state_reg <= IDLE;
`endif
        end

`ifdef SWAP_OP_EN
        WR_S: begin
          state_reg <= IDLE;
        end
`endif

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_xfer_ctrl.sv
// Self-checking bench for gpr_xfer_ctrl. A small register file sits on the
// read/write ports. A transaction-level model turns each accepted command
// into the list of per-cycle output values it must produce; a compare
// process checks every DUT output against that list on every cycle.
// Directed literal checks pin the model, then randomized traffic follows.
// Works with or without SWAP_OP_EN defined.
module tb_gpr_xfer_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [1:0]       cmd_rd = '0;
  logic [1:0]       cmd_rs = '0;
  logic [WIDTH-1:0] cmd_imm = '0;
  logic [WIDTH-1:0] rf_rdata;
  logic [1:0]       rf_sel_read;
  logic [1:0]       rf_sel_write;
  logic [WIDTH-1:0] rf_wdata;
  logic [3:0]       rf_load;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_xfer_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_rdata(rf_rdata), .rf_sel_read(rf_sel_read), .rf_sel_write(rf_sel_write),
    .rf_wdata(rf_wdata), .rf_load(rf_load), .busy(busy), .done(done), .err(err)
  );

  // Register file driven by the controller.
  logic [WIDTH-1:0] rf [4];
  assign rf_rdata = rf[rf_sel_read];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rf_load[i]) rf[i] <= rf_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       load;
    logic [1:0]       sel_r;
    logic [1:0]       sel_w;
    logic [WIDTH-1:0] wdata;
  } exp_t;

  exp_t             cur = '0;
  exp_t             plan_q[$];
  logic [WIDTH-1:0] mr [4] = '{default: '0};
  bit               started = 1'b0;

  function automatic exp_t ent(input logic b, input logic d, input logic e,
                               input logic [3:0] ld, input logic [1:0] sr,
                               input logic [1:0] sw, input logic [WIDTH-1:0] wd);
    exp_t x;
    x.busy = b; x.done = d; x.err = e; x.load = ld;
    x.sel_r = sr; x.sel_w = sw; x.wdata = wd;
    return x;
  endfunction

  // Cycle-by-cycle outputs of one command, starting the cycle after acceptance.
  task automatic plan(input logic [1:0] op, input logic [1:0] rd,
                      input logic [1:0] rs, input logic [WIDTH-1:0] imm);
    logic [3:0] ld_d;
    logic [3:0] ld_s;
    ld_d = 4'b0001 << rd;
    ld_s = 4'b0001 << rs;
    case (op)
      2'b00: plan_q.push_back(ent(1, 1, 0, ld_d, 2'd0, rd, imm));
      2'b11: plan_q.push_back(ent(1, 1, 0, ld_d, 2'd0, rd, '0));
      2'b01: begin
        plan_q.push_back(ent(1, 0, 0, 4'b0, rs, 2'd0, '0));
        plan_q.push_back(ent(1, 1, 0, ld_d, 2'd0, rd, mr[rs]));
      end
      default: begin
`ifdef SWAP_OP_EN
        plan_q.push_back(ent(1, 0, 0, 4'b0, rs, 2'd0, '0));
        plan_q.push_back(ent(1, 0, 0, 4'b0, rd, 2'd0, '0));
        plan_q.push_back(ent(1, 0, 0, ld_d, 2'd0, rd, mr[rs]));
        plan_q.push_back(ent(1, 1, 0, ld_s, 2'd0, rs, mr[rd]));
`else
        plan_q.push_back(ent(0, 0, 1, 4'b0, 2'd0, 2'd0, '0));
`endif
      end
    endcase
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cur.load[i]) mr[i] = cur.wdata;
    end
    if (rst) begin
      plan_q.delete();
      cur = '0;
      started = 1'b1;
    end else begin
      if (!cur.busy && cmd_valid) plan(cmd_op, cmd_rd, cmd_rs, cmd_imm);
      if (plan_q.size() > 0) cur = plan_q.pop_front();
      else cur = '0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cmd_ready", cmd_ready, !cur.busy && !rst);
      check("busy", busy, cur.busy && !rst);
      check("done", done, cur.done);
      check("err", err, cur.err);
      check("rf_load", rf_load, cur.load);
      check("rf_sel_read", rf_sel_read, cur.sel_r);
      check("rf_sel_write", rf_sel_write, cur.sel_w);
      check("rf_wdata", rf_wdata, cur.wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command, waits for acceptance, then drops cmd_valid and
  // scrambles the fields. Returns one cycle after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [WIDTH-1:0] imm);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("accept_timeout", cmd_ready, 1);
    $display("cmd op=%0d rd=%0d rs=%0d imm=%02h at %0t", op, rd, rs, imm, $time);
    step();
    cmd_valid = 1'b0;
    cmd_op  = 2'($urandom_range(0, 3));
    cmd_rd  = 2'($urandom_range(0, 3));
    cmd_rs  = 2'($urandom_range(0, 3));
    cmd_imm = WIDTH'($urandom);
  endtask

  initial begin
    int n;
    repeat (3) step();
    check("reset_ready", cmd_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_load", rf_load, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);

    // LDI rd=2 imm=A5
    issue(2'b00, 2'd2, 2'd0, 8'hA5);
    check("ldi_load", rf_load, 4'b0100);
    check("ldi_sel_write", rf_sel_write, 2);
    check("ldi_wdata", rf_wdata, 8'hA5);
    check("ldi_done", done, 1);
    step();
    check("ldi_ready_after", cmd_ready, 1);

    // R1=3C then MOV rs=1 rd=3
    issue(2'b00, 2'd1, 2'd0, 8'h3C);
    step();
    issue(2'b01, 2'd3, 2'd1, 8'h00);
    check("mov_sel_read", rf_sel_read, 1);
    check("mov_rd_load", rf_load, 0);
    step();
    check("mov_load", rf_load, 4'b1000);
    check("mov_wdata", rf_wdata, 8'h3C);
    check("mov_done", done, 1);
    step();

    // R0=11, R3=22, SWAP rs=0 rd=3
    issue(2'b00, 2'd0, 2'd0, 8'h11);
    step();
    issue(2'b00, 2'd3, 2'd0, 8'h22);
    step();
    issue(2'b10, 2'd3, 2'd0, 8'h00);
`ifdef SWAP_OP_EN
    check("swap_busy", busy, 1);
    step();
    check("swap_sel_read_rd", rf_sel_read, 3);
    step();
    check("swap_load_rd", rf_load, 4'b1000);
    check("swap_wdata_rd", rf_wdata, 8'h11);
    check("swap_done_early", done, 0);
    step();
    check("swap_load_rs", rf_load, 4'b0001);
    check("swap_wdata_rs", rf_wdata, 8'h22);
    check("swap_done", done, 1);
    step();
    check("swap_r0", rf[0], 8'h22);
    check("swap_r3", rf[3], 8'h11);
`else
    check("swap_err", err, 1);
    check("swap_no_load", rf_load, 0);
    check("swap_no_done", done, 0);
    check("swap_not_busy", busy, 0);
    step();
    check("swap_err_pulse", err, 0);
    check("swap_r3_kept", rf[3], 8'h22);
`endif

    // Queued commands with cmd_valid held high: CLR R1, then LDI R1=7F.
    cmd_op = 2'b11; cmd_rd = 2'd1; cmd_rs = 2'd0; cmd_imm = 8'h00;
    cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("queue_timeout", cmd_ready, 1);
    step();
    cmd_op = 2'b00; cmd_imm = 8'h7F;
    check("queue_clr_done", done, 1);
    check("queue_clr_wdata", rf_wdata, 0);
    check("queue_held_off", cmd_ready, 0);
    step();
    check("queue_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("queue_ldi_load", rf_load, 4'b0010);
    check("queue_ldi_wdata", rf_wdata, 8'h7F);
    step();
    check("queue_r1", rf[1], 8'h7F);

    // Reset in the middle of a command.
`ifdef SWAP_OP_EN
    issue(2'b10, 2'd2, 2'd1, 8'h00);
    step();
    check("abort_in_rd_d", rf_sel_read, 2);
`else
    issue(2'b01, 2'd2, 2'd1, 8'h00);
    check("abort_in_rd_s", rf_sel_read, 1);
`endif
    rst = 1'b1;
    step();
    check("abort_load", rf_load, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("abort_ready", cmd_ready, 1);
    step();
    check("abort_load_after", rf_load, 0);
    check("abort_r1", rf[1], 8'h7F);
    check("abort_r2", rf[2], 8'hA5);

    // Randomized traffic with gaps and occasional resets.
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) step();
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), WIDTH'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 2)) step();
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
    end

    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("drain_timeout", busy, 0);
    step();
    step();
    for (int i = 0; i < 4; i++) check("final_reg", rf[i], mr[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
